// File: rtl/shift_deserializer.sv
// Serial-in, parallel-out receiver: collects LSB-first bits into WIDTH-bit words and
// presents them on a valid/ready port, with early flush of partial words.
//
// state | meaning
// EMPTY | no unconsumed word; data_valid=0
// FULL  | data_out holds an unconsumed word; data_valid=1
module shift_deserializer #(
  parameter int              WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         serial_in,
  input  logic                         serial_valid,
  input  logic                         flush,
  input  logic                         shift_type,
  input  logic                         data_ready,
  input  logic                         clr_ovr,
  output logic [WIDTH-1:0]             data_out,
  output logic                         data_valid,
  output logic [$clog2(WIDTH+1)-1:0]   bit_cnt,
  output logic                         overrun
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             overrun_q, overrun_d;

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] ones;
  logic [WIDTH-1:0] word;
  logic [CW-1:0]    cnt_next;
  logic             new_word;
  logic             ovr_set;

  // Word assembly: completion and flush both hand a word to the output stage.
  always_comb begin
    ones      = '1;
    shifted   = serial_valid ? {serial_in, shreg_q[WIDTH-1:1]} : shreg_q;
    cnt_next  = bit_cnt_q + CW'(serial_valid);
    word      = '0;
    new_word  = 1'b0;
    shreg_d   = shifted;
    bit_cnt_d = cnt_next;
    if (cnt_next == CW'(WIDTH)) begin
      word      = shifted;
      new_word  = 1'b1;
      shreg_d   = '0;
      bit_cnt_d = '0;
    end else if (flush && (cnt_next != '0)) begin
      // Received bits sit at the top of shreg; the newest one is shifted[WIDTH-1].
      word = shifted >> (WIDTH - int'(cnt_next));
      if (shift_type && shifted[WIDTH-1]) begin
        word = word | (ones << cnt_next);
      end
      new_word  = 1'b1;
      shreg_d   = '0;
      bit_cnt_d = '0;
    end
  end

  always_comb begin
    state_d    = state_q;
    data_out_d = data_out_q;
    ovr_set    = 1'b0;
    case (state_q)
      EMPTY: begin
        if (new_word) begin
          data_out_d = word;
          state_d    = FULL;
        end
      end
      FULL: begin
        if (data_ready) begin
          if (new_word) begin
            data_out_d = word;
          end else begin
            state_d = EMPTY;
          end
        end else if (new_word) begin
          ovr_set = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    overrun_d = ovr_set | (overrun_q & ~clr_ovr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      data_out_q <= RST_VAL;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      data_out_q <= data_out_d;
      overrun_q  <= overrun_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = (state_q == FULL);
  assign bit_cnt    = bit_cnt_q;
  assign overrun    = overrun_q;

endmodule
